mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Parameters
REQ-001 SHALL have parameter DEPTH, default 64: number of 32-bit words stored; power of two, at least 4.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response valid; at least 1.

Interface
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  initiator accepts the response.
REQ-012 resp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE.
REQ-016 Acceptance SHALL occur on a rising edge where req_valid and req_ready are both 1; req_we, req_addr and req_wdata SHALL be captured at that edge.
REQ-017 On acceptance: LATENCY=1 SHALL go to RESP; LATENCY>1 SHALL go to WAIT with the counter loaded to LATENCY-2.
REQ-018 In WAIT: counter=0 SHALL go to RESP; otherwise the counter SHALL decrement.
REQ-019 resp_valid SHALL rise exactly LATENCY edges after the acceptance edge.
REQ-020 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until an edge with resp_ready=1.
REQ-021 On that edge the FSM SHALL return to IDLE; resp_ready=0 SHALL hold RESP indefinitely.
REQ-022 Only one request SHALL be outstanding; req_valid outside IDLE SHALL be ignored (no capture, no side effect).
REQ-023 Word index SHALL be addr[log2(DEPTH)+1:2].
- Error condition: addr[1:0]≠0 or addr ≥ 4*DEPTH.
- On error: resp_err=1, resp_rdata=0, no write.
REQ-024 A valid write SHALL update the memory on the edge entering RESP.
- Response: resp_rdata=0, resp_err=0.
REQ-025 A valid read SHALL sample the memory on the edge entering RESP.
- resp_rdata SHALL reflect all previously completed writes.
REQ-026 Back-to-back use SHALL be legal: a read following a write to the same address SHALL return the written data.
REQ-027 Arithmetic SHALL be unsigned; addresses SHALL NOT wrap.
- Addresses above range SHALL be treated as errors, not aliased.

Reset
REQ-028 reset=0 SHALL asynchronously force:
- state IDLE, counter 0;
- req_ready=0 while reset is asserted, then 1 from the first cycle after release;
- resp_valid=0, resp_rdata=0, resp_err=0.
REQ-029 Reset in WAIT or RESP SHALL drop the in-flight request.
- A write not yet committed (reset before the edge entering RESP) SHALL NOT update memory.
REQ-030 Memory contents SHALL NOT be cleared by reset; reads of never-written words return undefined data.

Verification
REQ-031 Write then read, LATENCY=2:
- write 0x0000_0010 ← 0xDEAD_BEEF; resp_valid 2 cycles after acceptance, rdata 0, err 0.
- read 0x10 returns 0xDEAD_BEEF, err 0.
REQ-032 Backpressure:
- read with resp_ready=0 for 5 cycles: resp_valid and rdata held stable, req_ready=0 throughout.
- resp_ready=1: IDLE on the next edge, req_ready=1.
REQ-033 Misaligned write to 0x0000_0012 ← 0x1234_5678:
- err=1, rdata=0.
- a following read of 0x10 still returns its prior value.
REQ-034 Out-of-range read of 0x0000_0100 with DEPTH=64: err=1, rdata=0.
REQ-035 Reset mid-write:
- word 0x20 = 0x1111_1111; accept write 0x20 ← 0x2222_2222; assert reset during WAIT.
- After release: resp_valid=0, req_ready=1; read of 0x20 returns 0x1111_1111.
REQ-036 Ignored request and latency sweep:
- req_valid held high during WAIT with a different address: only the first request is served.
- Repeat with LATENCY=1 and LATENCY=4: response exactly 1 and 4 edges after acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding word memory responder with fixed response latency
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   mem [DEPTH];

  logic          accept, commit;
  logic          op_we, op_err;
  logic [31:0]   op_addr, op_wdata;
  logic [AW-1:0] op_idx;

  assign req_ready  = (state == IDLE) && reset;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // With LATENCY=1 the commit happens on the acceptance edge, so use the live request.
  assign op_we    = (state == IDLE) ? req_we    : we_q;
  assign op_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign op_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign op_err   = (op_addr[1:0] != 2'b00) || ({1'b0, op_addr} >= LIMIT);
  assign op_idx   = op_addr[AW+1:2];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        resp_err   <= op_err;
        resp_rdata <= (op_err || op_we) ? 32'h0 : mem[op_idx];
      end
    end
  end

  // Storage survives reset; only a committed, in-range, aligned write lands.
  always_ff @(posedge clk) begin
    if (commit && op_we && !op_err) mem[op_idx] <= op_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - bench for mem_responder at LATENCY 1, 2 and 4
`timescale 1ns/1ps
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.DEPTH(64), .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g])
    );
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] model [3][64];
  bit          known [3][64];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [10];

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed word store, 256 bytes, aligned accesses only.
  task automatic model_apply(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] exp_r, output bit exp_e, output bit r_known);
    int idx;
    exp_e   = (addr % 4 != 0) || (addr >= 32'd256);
    exp_r   = 32'h0;
    r_known = 1'b1;
    if (!exp_e) begin
      idx = int'(addr / 4);
      if (we) begin
        model[d][idx] = wdata;
        known[d][idx] = 1'b1;
      end else begin
        exp_r   = model[d][idx];
        r_known = known[d][idx];
      end
    end
  endtask

  task automatic do_req(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, input bit hold, output logic [31:0] rdata, output logic err);
    int n;
    logic [31:0] r0;
    logic e0;
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_valid[d] = 1'b1;
    check("req_ready_idle", req_ready[d], 1);
    @(posedge clk); #1;
    if (hold) begin
      req_we[d] = 1'b1; req_addr[d] = addr ^ 32'h40; req_wdata[d] = ~wdata;
    end else begin
      req_valid[d] = 1'b0;
    end
    n = 1;
    while (!resp_valid[d] && n < 20) begin
      check("req_ready_busy", req_ready[d], 0);
      @(posedge clk); #1;
      n++;
    end
    check("resp_latency", n, lat_of(d));
    r0 = resp_rdata[d];
    e0 = resp_err[d];
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_valid", resp_valid[d], 1);
      check("hold_rdata", resp_rdata[d], r0);
      check("hold_err", resp_err[d], e0);
      check("hold_req_ready", req_ready[d], 0);
    end
    rdata = r0;
    err   = e0;
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
    check("idle_resp_valid", resp_valid[d], 0);
    check("idle_req_ready", req_ready[d], 1);
  endtask

  task automatic run(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int stall, input bit hold);
    logic [31:0] r, er;
    logic e;
    bit ee, rk;
    do_req(d, we, addr, wdata, stall, hold, r, e);
    model_apply(d, we, addr, wdata, er, ee, rk);
    check("rand_err", e, ee);
    if (rk) check("rand_rdata", r, er);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, dr;
    logic e;
    bit de, dk;
    logic [31:0] a;
    int sel, w;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0012, 32'h1234_5678, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0100, 32'h0,         32'h0,         1'b1};
    vecs[5] = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 32'h0,         1'b0};
    vecs[6] = '{1'b0, 32'h0000_00FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};
    vecs[8] = '{1'b1, 32'h0000_0101, 32'h5555_5555, 32'h0,         1'b1};
    vecs[9] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};

    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; resp_ready[d] = 1'b0;
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_req_ready", req_ready[d], 0);
      check("rst_resp_valid", resp_valid[d], 0);
      check("rst_resp_rdata", resp_rdata[d], 0);
      check("rst_resp_err", resp_err[d], 0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) check("post_rst_req_ready", req_ready[d], 1);

    // Directed table on the LATENCY=2 instance; word 0 written first so vector 9 is defined.
    run(1, 1'b1, 32'h0, 32'h0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_req(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, 1'b0, r, e);
      model_apply(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, dr, de, dk);
      check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
    end

    do_req(1, 1'b0, 32'h10, 32'h0, 5, 1'b0, r, e);
    check("bp_rdata", r, 32'hDEAD_BEEF);

    run(1, 1'b1, 32'h20, 32'h1111_1111, 0, 1'b0);
    req_we[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'h2222_2222; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("mid_wait_valid", resp_valid[1], 0);
    reset = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready[1], 0);
    check("mid_rst_resp_valid", resp_valid[1], 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_req_ready", req_ready[1], 1);
    check("mid_rel_resp_valid", resp_valid[1], 0);
    do_req(1, 1'b0, 32'h20, 32'h0, 0, 1'b0, r, e);
    check("mid_rst_read", r, 32'h1111_1111);

    // Held request during the busy phase must not land at addr^0x40.
    for (int d = 0; d < 3; d++) begin
      run(d, 1'b1, 32'h64, 32'h0, 0, 1'b0);
      run(d, 1'b1, 32'h24, 32'hCAFE_0000 + d, 1, 1'b1);
      do_req(d, 1'b0, 32'h64, 32'h0, 0, 1'b0, r, e);
      check("ignored_req_word", r, 32'h0);
      do_req(d, 1'b0, 32'h24, 32'h0, 0, 1'b0, r, e);
      check("served_req_word", r, 32'hCAFE_0000 + d);
    end

    for (int d = 0; d < 3; d++) begin
      for (int t = 0; t < 60; t++) begin
        sel = $urandom_range(0, 9);
        w = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(56, 63);
        if (sel < 7)       a = 32'(w * 4);
        else if (sel == 7) a = 32'(w * 4 + $urandom_range(1, 3));
        else if (sel == 8) a = 32'(256 + $urandom_range(0, 1000) * 4);
        else               a = 32'hFFFF_FFF0;
        run(d, $urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
